// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared widths, FSM state encoding and MEM/WB bubble constants
//            for the MIPS memory-access stage.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Access sequencer states
    typedef logic [0:0] state_t;
    localparam state_t c_st_idle = 1'b0;
    localparam state_t c_st_busy = 1'b1;

    // Field values loaded into MEM/WB when the slot carries no instruction
    localparam logic              c_bubble_ctrl = 1'b0;
    localparam logic [REG_W-1:0]  c_bubble_dest = '0;
    localparam logic [DATA_W-1:0] c_bubble_word = '0;

    // Word accesses only: the two byte-offset bits must be clear
    function automatic logic is_word_aligned(input logic [DATA_W-1:0] byte_addr);
        return (byte_addr[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_if
// Purpose  : EX/MEM inputs and MEM/WB outputs of the memory-access stage.
// Ports    : in_*   - EX/MEM fields (valid, mem_read, mem_write, mem_to_reg,
//                     reg_write, destination, alu_result, write_data)
//            *_out  - MEM/WB fields, stall_out, misaligned_out
//            master - drives in_* (EX/MEM side), slave - the stage itself
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              in_valid;
    logic              in_mem_read;
    logic              in_mem_write;
    logic              in_mem_to_reg;
    logic              in_reg_write;
    logic [REG_W-1:0]  in_write_back_destination;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_write_data;

    logic              mem_to_reg_out;
    logic              reg_write_out;
    logic [REG_W-1:0]  write_back_destination_out;
    logic [DATA_W-1:0] address_out;
    logic [DATA_W-1:0] read_data_out;
    logic              stall_out;
    logic              misaligned_out;

    modport master (
        output in_valid, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write,
               in_write_back_destination, in_alu_result, in_write_data,
        input  mem_to_reg_out, reg_write_out, write_back_destination_out,
               address_out, read_data_out, stall_out, misaligned_out
    );

    modport slave (
        input  in_valid, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write,
               in_write_back_destination, in_alu_result, in_write_data,
        output mem_to_reg_out, reg_write_out, write_back_destination_out,
               address_out, read_data_out, stall_out, misaligned_out
    );

endinterface
`default_nettype wire

// File: rtl/mem_stage_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_data_memory
// Purpose  : Single-port synchronous word RAM, DEPTH x 32, read-before-write.
// Ports    : clk     - rising-edge clock
//            i_en    - perform an access at this edge (read always, write if i_we)
//            i_we    - write i_wdata to word i_addr
//            i_addr  - word index
//            i_wdata - write data
//            o_rdata - registered read data (pre-write contents of i_addr)
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_data_memory
    import mem_stage_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  wire logic              clk,
    input  wire logic              i_en,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Contents have no reset; the read register holds between accesses
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : MIPS memory-access stage: data memory, configurable-latency
//            access sequencer and the MEM/WB pipeline register.
// Ports    : clk - rising-edge clock
//            rst - synchronous active-high reset
//            bus - mem_stage_if.slave (EX/MEM inputs, MEM/WB outputs,
//                  combinational stall_out, registered misaligned_out pulse)
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int MEM_LATENCY = 0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mem_stage_if.slave  bus
);

    localparam logic [3:0] c_lat = 4'(MEM_LATENCY);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_mem_to_reg;
    logic              r_reg_write;
    logic [REG_W-1:0]  r_dest;
    logic [DATA_W-1:0] r_addr;
    logic              r_load_sel;
    logic              r_misaligned;

    logic              w_mem_op;
    logic              w_aligned;
    logic              w_stall;
    logic              w_complete;
    logic              w_ram_en;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_rdata;

    always_comb begin
        w_mem_op   = bus.in_valid & (bus.in_mem_read | bus.in_mem_write);
        w_aligned  = is_word_aligned(bus.in_alu_result);
        w_stall    = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_stall    = w_mem_op && (c_lat != 4'd0);
                w_complete = w_mem_op && (c_lat == 4'd0);
            end
            c_st_busy: begin
                // Upstream holds the op stable while stalled, so only the
                // count decides when the access completes.
                w_stall    = (r_cnt != c_lat);
                w_complete = (r_cnt == c_lat);
            end
            default: begin
                w_stall    = 1'b0;
                w_complete = 1'b0;
            end
        endcase
        // rst gates the RAM so an access aborted by reset never commits
        w_ram_en = w_complete & ~rst;
        w_ram_we = w_ram_en & bus.in_mem_write & w_aligned;
    end

    mem_stage_data_memory #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_memory (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (bus.in_alu_result[ADDR_W+1:2]),
        .i_wdata (bus.in_write_data),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_cnt        <= 4'd0;
            r_mem_to_reg <= c_bubble_ctrl;
            r_reg_write  <= c_bubble_ctrl;
            r_dest       <= c_bubble_dest;
            r_addr       <= c_bubble_word;
            r_load_sel   <= c_bubble_ctrl;
            r_misaligned <= c_bubble_ctrl;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_stall) begin
                        r_state <= c_st_busy;
                        r_cnt   <= 4'd1;
                    end
                end
                c_st_busy: begin
                    if (w_complete) begin
                        r_state <= c_st_idle;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= 4'd0;
                end
            endcase

            if (w_stall || !bus.in_valid) begin
                r_mem_to_reg <= c_bubble_ctrl;
                r_reg_write  <= c_bubble_ctrl;
                r_dest       <= c_bubble_dest;
                r_addr       <= c_bubble_word;
                r_load_sel   <= c_bubble_ctrl;
                r_misaligned <= c_bubble_ctrl;
            end else begin
                r_mem_to_reg <= bus.in_mem_to_reg;
                // A misaligned memory op must not update the register file
                r_reg_write  <= bus.in_reg_write & ~(w_mem_op & ~w_aligned);
                r_dest       <= bus.in_write_back_destination;
                r_addr       <= bus.in_alu_result;
                r_load_sel   <= bus.in_mem_read & w_aligned;
                r_misaligned <= w_mem_op & ~w_aligned;
            end
        end
    end

    // The RAM's read register acts as the MEM/WB data field; r_load_sel
    // zeroes it for everything that is not an aligned load.
    assign bus.mem_to_reg_out             = r_mem_to_reg;
    assign bus.reg_write_out              = r_reg_write;
    assign bus.write_back_destination_out = r_dest;
    assign bus.address_out                = r_addr;
    assign bus.read_data_out              = r_load_sel ? w_ram_rdata : c_bubble_word;
    assign bus.stall_out                  = w_stall;
    assign bus.misaligned_out             = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Scoreboard bench for mem_stage; one instance with no extra
//            latency and one with three extra cycles.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;

    mem_stage_if bus0 ();
    mem_stage_if bus1 ();

    mem_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LATENCY(0)) u_dut0 (
        .clk (clk), .rst (rst0), .bus (bus0)
    );

    mem_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LATENCY(3)) u_dut1 (
        .clk (clk), .rst (rst1), .bus (bus1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          is_stall;
        string       nm;
        logic        st;
        logic        m2r;
        logic        rw;
        logic [4:0]  dst;
        logic [31:0] addr;
        logic [31:0] rd;
        logic        mis;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic check_rec(input int d, input rec_t r);
        logic        st, m2r, rw, mis;
        logic [4:0]  dst;
        logic [31:0] addr, rd;
        string       p;
        if (d == 0) begin
            st = bus0.stall_out; m2r = bus0.mem_to_reg_out; rw = bus0.reg_write_out;
            dst = bus0.write_back_destination_out; addr = bus0.address_out;
            rd = bus0.read_data_out; mis = bus0.misaligned_out;
        end else begin
            st = bus1.stall_out; m2r = bus1.mem_to_reg_out; rw = bus1.reg_write_out;
            dst = bus1.write_back_destination_out; addr = bus1.address_out;
            rd = bus1.read_data_out; mis = bus1.misaligned_out;
        end
        p = $sformatf("d%0d c%0d %s", d, r.cyc, r.nm);
        if (r.is_stall) begin
            cmp({p, " stall"}, {31'd0, st}, {31'd0, r.st});
        end else begin
            cmp({p, " mem_to_reg"}, {31'd0, m2r}, {31'd0, r.m2r});
            cmp({p, " reg_write"},  {31'd0, rw},  {31'd0, r.rw});
            cmp({p, " dest"},       {27'd0, dst}, {27'd0, r.dst});
            cmp({p, " address"},    addr,         r.addr);
            cmp({p, " read_data"},  rd,           r.rd);
            cmp({p, " misaligned"}, {31'd0, mis}, {31'd0, r.mis});
        end
    endtask

    // Monitor: pops every expectation due in the current cycle
    always @(negedge clk) begin
        while (q0.size() > 0 && q0[0].cyc <= cyc) begin
            rec_t r;
            r = q0.pop_front();
            if (r.cyc < cyc) begin
                n_checks++;
                $display("FAIL d0 %s stale: got cycle %0d expected cycle %0d", r.nm, cyc, r.cyc);
            end else check_rec(0, r);
        end
        while (q1.size() > 0 && q1[0].cyc <= cyc) begin
            rec_t r;
            r = q1.pop_front();
            if (r.cyc < cyc) begin
                n_checks++;
                $display("FAIL d1 %s stale: got cycle %0d expected cycle %0d", r.nm, cyc, r.cyc);
            end else check_rec(1, r);
        end
    end

    function automatic rec_t mk_out(input int c, input string nm, input logic m2r, input logic rw,
                                    input logic [4:0] dst, input logic [31:0] addr,
                                    input logic [31:0] rd, input logic mis);
        rec_t r;
        r.cyc = c; r.is_stall = 1'b0; r.nm = nm; r.st = 1'b0;
        r.m2r = m2r; r.rw = rw; r.dst = dst; r.addr = addr; r.rd = rd; r.mis = mis;
        return r;
    endfunction

    function automatic rec_t mk_stall(input int c, input string nm, input logic st);
        rec_t r;
        r = mk_out(c, nm, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        r.is_stall = 1'b1;
        r.st = st;
        return r;
    endfunction

    task automatic push(input int d, input rec_t r);
        if (d == 0) q0.push_back(r);
        else        q1.push_back(r);
    endtask

    task automatic drive(input int d, input logic v, input logic rd, input logic wr,
                         input logic m2r, input logic rw, input logic [4:0] dst,
                         input logic [31:0] alu, input logic [31:0] wd);
        if (d == 0) begin
            bus0.in_valid = v; bus0.in_mem_read = rd; bus0.in_mem_write = wr;
            bus0.in_mem_to_reg = m2r; bus0.in_reg_write = rw;
            bus0.in_write_back_destination = dst; bus0.in_alu_result = alu;
            bus0.in_write_data = wd;
        end else begin
            bus1.in_valid = v; bus1.in_mem_read = rd; bus1.in_mem_write = wr;
            bus1.in_mem_to_reg = m2r; bus1.in_reg_write = rw;
            bus1.in_write_back_destination = dst; bus1.in_alu_result = alu;
            bus1.in_write_data = wd;
        end
    endtask

    // Holds one instruction for as long as the stage stalls; bench latency
    // constants: instance 0 -> 0 extra cycles, instance 1 -> 3.
    task automatic issue(input int d, input string nm,
                         input logic v, input logic rd, input logic wr, input logic m2r,
                         input logic rw, input logic [4:0] dst, input logic [31:0] alu,
                         input logic [31:0] wd,
                         input logic e_m2r, input logic e_rw, input logic [4:0] e_dst,
                         input logic [31:0] e_addr, input logic [31:0] e_rd, input logic e_mis);
        int lat;
        int n;
        lat = (d == 0) ? 0 : 3;
        n   = (v && (rd || wr)) ? lat : 0;
        drive(d, v, rd, wr, m2r, rw, dst, alu, wd);
        for (int k = 0; k <= n; k++) begin
            push(d, mk_stall(cyc, nm, (k < n)));
            if (k < n) push(d, mk_out(cyc + 1, {nm, " bubble"}, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0));
            else       push(d, mk_out(cyc + 1, nm, e_m2r, e_rw, e_dst, e_addr, e_rd, e_mis));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        drive(1, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        push(0, mk_out(cyc, "reset", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0));
        push(1, mk_out(cyc, "reset", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0));
        push(0, mk_stall(cyc, "reset", 1'b0));
        rst0 = 1'b0;
        rst1 = 1'b0;

        // ---------------- no extra latency ----------------
        issue(0, "alu op", 1,0,0,0,1, 5'd5, 32'h0000_1234, 32'd0,  0,1,5'd5, 32'h0000_1234, 32'd0, 0);
        issue(0, "store 0x10", 1,0,1,0,0, 5'd0, 32'h10, 32'hDEAD_BEEF,  0,0,5'd0, 32'h10, 32'd0, 0);
        issue(0, "load 0x10", 1,1,0,1,1, 5'd8, 32'h10, 32'd0,  1,1,5'd8, 32'h10, 32'hDEAD_BEEF, 0);
        issue(0, "misaligned store 0x13", 1,0,1,0,1, 5'd6, 32'h13, 32'h1111_1111,  0,0,5'd6, 32'h13, 32'd0, 1);
        issue(0, "load 0x10 after mis", 1,1,0,1,1, 5'd8, 32'h10, 32'd0,  1,1,5'd8, 32'h10, 32'hDEAD_BEEF, 0);
        issue(0, "misaligned load 0x12", 1,1,0,1,1, 5'd3, 32'h12, 32'd0,  1,0,5'd3, 32'h12, 32'd0, 1);
        issue(0, "store wrap 0x400", 1,0,1,0,0, 5'd0, 32'h400, 32'h55,  0,0,5'd0, 32'h400, 32'd0, 0);
        issue(0, "load 0x000", 1,1,0,1,1, 5'd9, 32'h0, 32'd0,  1,1,5'd9, 32'h0, 32'h55, 0);
        issue(0, "read+write 0x10", 1,1,1,1,1, 5'd4, 32'h10, 32'h1234_5678,  1,1,5'd4, 32'h10, 32'hDEAD_BEEF, 0);
        issue(0, "invalid slot", 0,0,1,1,1, 5'd7, 32'h10, 32'h0000_0BAD,  0,0,5'd0, 32'd0, 32'd0, 0);
        issue(0, "load 0x10 new", 1,1,0,1,1, 5'd10, 32'h10, 32'd0,  1,1,5'd10, 32'h10, 32'h1234_5678, 0);
        drive(0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);

        // ---------------- three extra cycles ----------------
        issue(1, "L3 store 0 to 0x20", 1,0,1,0,0, 5'd0, 32'h20, 32'd0,  0,0,5'd0, 32'h20, 32'd0, 0);
        issue(1, "L3 store 0x10", 1,0,1,0,0, 5'd0, 32'h10, 32'hDEAD_BEEF,  0,0,5'd0, 32'h10, 32'd0, 0);
        issue(1, "L3 load 0x10", 1,1,0,1,1, 5'd8, 32'h10, 32'd0,  1,1,5'd8, 32'h10, 32'hDEAD_BEEF, 0);
        issue(1, "L3 misaligned store 0x13", 1,0,1,0,1, 5'd6, 32'h13, 32'h77,  0,0,5'd6, 32'h13, 32'd0, 1);
        issue(1, "L3 load 0x10 after mis", 1,1,0,1,1, 5'd8, 32'h10, 32'd0,  1,1,5'd8, 32'h10, 32'hDEAD_BEEF, 0);
        issue(1, "L3 alu op", 1,0,0,0,1, 5'd12, 32'h0000_ABCD, 32'd0,  0,1,5'd12, 32'h0000_ABCD, 32'd0, 0);

        // Store aborted by reset in BUSY cycle 2
        drive(1, 1, 0, 1, 0, 0, 5'd0, 32'h20, 32'hCAFE_0000);
        push(1, mk_stall(cyc, "abort c0", 1'b1));
        push(1, mk_out(cyc + 1, "abort bubble", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0));
        @(posedge clk); #1;
        push(1, mk_stall(cyc, "abort c1", 1'b1));
        push(1, mk_out(cyc + 1, "abort bubble", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0));
        @(posedge clk); #1;
        rst1 = 1'b1;
        push(1, mk_stall(cyc, "abort c2", 1'b1));
        push(1, mk_out(cyc + 1, "after reset", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0));
        @(posedge clk); #1;
        rst1 = 1'b0;
        // Store fields still present but slot invalid: nothing may commit
        issue(1, "idle after reset", 0,0,1,0,0, 5'd0, 32'h20, 32'hCAFE_0000,  0,0,5'd0, 32'd0, 32'd0, 0);
        issue(1, "L3 load 0x20", 1,1,0,1,1, 5'd2, 32'h20, 32'd0,  1,1,5'd2, 32'h20, 32'd0, 0);
        drive(1, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);

        for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) begin
            @(posedge clk); #1;
        end
        if (q0.size() > 0 || q1.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
